// File: rtl/load_store_unit.sv
// Memory-access stage: one sized load/store per start pulse, with lane steering,
// load extension, alignment checking and a bounded wait on dmem_ready.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // REQ   | dmem_req held until dmem_ready or timeout
    // DONE  | one-cycle done pulse, results valid
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  cnt;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_val;

    always_comb begin
        misalign = 1'b0;
        case (mem_op[1:0])
            2'b01:   misalign = addr[0];
            2'b10:   misalign = (addr[1:0] != 2'b00);
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = misalign ? DONE : REQ;
            REQ:     if (dmem_ready || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        be_calc    = 4'b0000;
        wdata_calc = 32'h0;
        case (op_q[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr_q[1:0];
                wdata_calc = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_calc    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata_q[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_q;
            end
        endcase
    end

    always_comb begin
        load_val = dmem_rdata;
        case (op_q[1:0])
            2'b00: begin
                logic [7:0] b;
                b = dmem_rdata[8*addr_q[1:0] +: 8];
                load_val = op_q[2] ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                logic [15:0] h;
                h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
                load_val = op_q[2] ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        dmem_req   = (state == REQ);
        dmem_we    = 1'b0;
        dmem_be    = 4'b0000;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        if (state == REQ) begin
            dmem_we    = op_q[3];
            dmem_be    = be_calc;
            dmem_addr  = {addr_q[31:2], 2'b00};
            dmem_wdata = wdata_calc;
        end
    end

    // Request latch, wait counter and sticky results (held until next accepted start).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'h0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            cnt      <= 8'h0;
            rdata    <= 32'h0;
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q     <= mem_op;
                    addr_q   <= addr;
                    wdata_q  <= wdata;
                    cnt      <= 8'h0;
                    rdata    <= 32'h0;
                    addr_err <= misalign;
                    bus_err  <= 1'b0;
                end
                REQ: begin
                    if (dmem_ready) begin
                        if (!op_q[3]) rdata <= load_val;
                    end else if (timeout_hit) begin
                        bus_err <= 1'b1;
                        rdata   <= 32'h0;
                    end else begin
                        cnt <= cnt + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
